// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared types and step indices for the calc sequencer
package calc_pkg;

  typedef enum logic [2:0] {IDLE, CALC, DIVW, FIN, DONE} calc_state_t;

  typedef enum logic {ADD, SUB} alu_op_t;

  localparam logic [2:0] STEP_AB  = 3'd0;
  localparam logic [2:0] STEP_S5  = 3'd1;
  localparam logic [2:0] STEP_T   = 3'd2;
  localparam logic [2:0] STEP_S4  = 3'd3;
  localparam logic [2:0] STEP_U0  = 3'd4;
  localparam logic [2:0] STEP_UD  = 3'd5;
  localparam logic [2:0] STEP_UC  = 3'd6;
  localparam logic [2:0] STEP_S6  = 3'd7;

endpackage

// File: rtl/calc_iter_div.sv
// rtl/calc_iter_div.sv - restoring divider, one bit per clock, remainder only
// The first iteration runs on the start edge so done is visible BW-1 edges later.
module calc_iter_div #(
  parameter int BW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [BW-1:0] dividend,
  input  logic [BW-1:0] divisor,
  output logic          done,
  output logic [BW-1:0] rem
);

  localparam int CW = $clog2(BW + 1);

  logic [BW-1:0] dvd_q;
  logic [BW-1:0] dvs_q;
  logic [CW-1:0] cnt_q;
  logic          run_q;

  logic [BW-1:0] rem_in;
  logic [BW-1:0] dvs_in;
  logic          bit_in;
  logic [BW:0]   trial;
  logic [BW-1:0] rem_next;

  // A zero divisor always "fits", so the remainder just shifts in the dividend.
  always_comb begin
    rem_in = start ? '0 : rem;
    bit_in = start ? dividend[BW-1] : dvd_q[BW-1];
    dvs_in = start ? divisor : dvs_q;
    trial  = {rem_in, bit_in};
    if (trial >= {1'b0, dvs_in})
      rem_next = BW'(trial - {1'b0, dvs_in});
    else
      rem_next = trial[BW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem   <= '0;
      dvd_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
      done  <= 1'b0;
    end else if (start) begin
      rem   <= rem_next;
      dvd_q <= dividend << 1;
      dvs_q <= divisor;
      cnt_q <= CW'(BW - 1);
      run_q <= (BW > 1);
      done  <= (BW == 1);
    end else if (run_q) begin
      rem   <= rem_next;
      dvd_q <= dvd_q << 1;
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        run_q <= 1'b0;
        done  <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/calc_seq_ctrl.sv
// rtl/calc_seq_ctrl.sv - time-multiplexed ALU/multiplier sequencer producing s1..s6
// Define CALC_MOD_EN to add the iterative divider and the s3 = (a % b) + d path.
module calc_seq_ctrl
  import calc_pkg::*;
#(
  parameter int BW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [BW-1:0] a,
  input  logic [BW-1:0] b,
  input  logic [BW-1:0] c,
  input  logic [BW-1:0] d,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [BW-1:0] s1,
  output logic [BW-1:0] s2,
  output logic [BW-1:0] s3,
  output logic [BW-1:0] s4,
  output logic [BW-1:0] s5,
  output logic [BW-1:0] s6,
  output logic          busy
);

  calc_state_t   state;
  logic [2:0]    step;
  logic [BW-1:0] a_r, b_r, c_r, d_r;
  logic [BW-1:0] p, t, u;
  logic          accept;
  logic [BW-1:0] mul_lo;
  alu_op_t       alu_op;
  logic [BW-1:0] alu_x, alu_y, alu_res;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign accept   = in_valid && in_ready;
  assign mul_lo   = a_r * b_r;

`ifdef CALC_MOD_EN
  logic          div_done;
  logic [BW-1:0] div_rem;

  // Divider takes operands straight from the ports on the accept edge.
  calc_iter_div #(.BW(BW)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (accept),
    .dividend (a),
    .divisor  (b),
    .done     (div_done),
    .rem      (div_rem)
  );
`endif

  always_comb begin
    alu_op = ADD;
    alu_x  = a_r;
    alu_y  = b_r;
    case (step)
      STEP_S5: alu_op = SUB;
      STEP_T:  begin alu_x = c_r; alu_y = d_r; end
      STEP_S4: begin alu_x = t;   alu_y = p;   end
      STEP_U0: begin alu_x = p;   alu_y = a_r; end
      STEP_UD: begin alu_x = u;   alu_y = d_r; end
      STEP_UC: begin alu_x = u;   alu_y = c_r; end
      STEP_S6: begin alu_op = SUB; alu_x = u; alu_y = b_r; end
      default: ;
    endcase
`ifdef CALC_MOD_EN
    if (state == FIN) begin
      alu_op = ADD;
      alu_x  = div_rem;
      alu_y  = d_r;
    end
`endif
    alu_res = (alu_op == ADD) ? alu_x + alu_y : alu_x - alu_y;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      step      <= '0;
      a_r       <= '0;
      b_r       <= '0;
      c_r       <= '0;
      d_r       <= '0;
      p         <= '0;
      t         <= '0;
      u         <= '0;
      s1        <= '0;
      s2        <= '0;
      s3        <= '0;
      s4        <= '0;
      s5        <= '0;
      s6        <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          a_r   <= a;
          b_r   <= b;
          c_r   <= c;
          d_r   <= d;
          step  <= STEP_AB;
          state <= CALC;
        end
        CALC: begin
          step <= step + 3'd1;
          case (step)
            STEP_AB: begin p <= mul_lo; s1 <= alu_res; end
            STEP_S5: s5 <= alu_res;
            STEP_T:  t  <= alu_res;
            STEP_S4: s4 <= alu_res;
            STEP_U0, STEP_UD, STEP_UC: u <= alu_res;
            STEP_S6: begin
              s6 <= alu_res;
`ifdef CALC_MOD_EN
              state <= div_done ? FIN : DIVW;
`else
              s3        <= d_r;
              s2        <= p;
              out_valid <= 1'b1;
              state     <= DONE;
`endif
            end
          endcase
        end
`ifdef CALC_MOD_EN
        DIVW: if (div_done) state <= FIN;
        FIN: begin
          s3        <= alu_res;
          s2        <= p;
          out_valid <= 1'b1;
          state     <= DONE;
        end
`endif
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// tb/tb_calc_seq_ctrl.sv - directed self-checking bench for calc_seq_ctrl (BW=8)
module tb_calc_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = '0, b = '0, c = '0, d = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] s1, s2, s3, s4, s5, s6;
  logic       busy;

  int vectors = 0;
  int fails   = 0;

`ifdef CALC_MOD_EN
  localparam int LAT = 9;
`else
  localparam int LAT = 8;
`endif

  calc_seq_ctrl #(.BW(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s1        (s1),
    .s2        (s2),
    .s3        (s3),
    .s4        (s4),
    .s5        (s5),
    .s6        (s6),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic start_job(input logic [7:0] ja, jb, jc, jd);
    @(negedge clk);
    in_valid = 1'b1;
    a = ja; b = jb; c = jc; d = jd;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); d = 8'($urandom);
  endtask

  task automatic wait_result(input string tag);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      seen = out_valid;
    end
    check(tag, seen ? n : 99, LAT);
  endtask

  task automatic check_all(input string tag, input logic [7:0] e1, e2, e3, e4, e5, e6);
    check({tag, ".s1"}, s1, e1);
    check({tag, ".s2"}, s2, e2);
    check({tag, ".s3"}, s3, e3);
    check({tag, ".s4"}, s4, e4);
    check({tag, ".s5"}, s5, e5);
    check({tag, ".s6"}, s6, e6);
  endtask

  task automatic consume(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, ".ov_clr"}, out_valid, 0);
    check({tag, ".in_ready"}, in_ready, 1);
    check({tag, ".busy"}, busy, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst.in_ready", in_ready, 1);
    check("rst.busy", busy, 0);
    check("rst.out_valid", out_valid, 0);
    check_all("rst", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    start_job(8'd7, 8'd3, 8'd2, 8'd5);
    check("basic.busy", busy, 1);
    check("basic.in_ready", in_ready, 0);
    wait_result("basic.latency");
`ifdef CALC_MOD_EN
    check_all("basic", 10, 21, 6, 28, 4, 32);
`else
    check_all("basic", 10, 21, 5, 28, 4, 32);
`endif
    consume("basic");

    // Results held under backpressure while a new offer is presented.
    start_job(8'd200, 8'd100, 8'd50, 8'd60);
    wait_result("wrap.latency");
    check_all("wrap", 44, 32, 60, 142, 100, 242);
    @(negedge clk);
    in_valid = 1'b1;
    a = 8'd1; b = 8'd1; c = 8'd1; d = 8'd1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp.out_valid", out_valid, 1);
      check("bp.in_ready", in_ready, 0);
      check("bp.s1", s1, 44);
      check("bp.s6", s6, 242);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp.ov_clr", out_valid, 0);
    check("bp.idle", in_ready, 1);
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    check("bp.no_accept", busy, 0);

    start_job(8'd9, 8'd0, 8'd1, 8'd1);
    wait_result("div0.latency");
`ifdef CALC_MOD_EN
    check_all("div0", 9, 0, 10, 2, 9, 11);
`else
    check_all("div0", 9, 0, 1, 2, 9, 11);
`endif
    check("div0.no_x", $isunknown({s1, s2, s3, s4, s5, s6, out_valid, in_ready, busy}), 0);
    consume("div0");

    start_job(8'd7, 8'd3, 8'd2, 8'd5);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.in_ready", in_ready, 1);
    check("arst.busy", busy, 0);
    check("arst.out_valid", out_valid, 0);
    check_all("arst", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    start_job(8'd3, 8'd5, 8'd0, 8'd0);
    wait_result("post.latency");
`ifdef CALC_MOD_EN
    check_all("post", 8, 15, 3, 15, 254, 13);
`else
    check_all("post", 8, 15, 0, 15, 254, 13);
`endif
    consume("post");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
